// File: rtl/wb_word64_master.sv
// Wishbone classic initiator performing 32/64-bit register accesses for a
// local requester. 64-bit accesses run as two 32-bit beats (A low, A+1 high);
// a consistent read fetches hi-lo-hi and retries until the high words agree.
module wb_word64_master #(
  parameter int PADDR_SIZE     = 30,
  parameter int PDATA_SIZE     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RETRY_MAX      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic                    req_size64,
  input  logic                    req_consistent,
  input  logic [PADDR_SIZE-1:0]   req_adr,
  input  logic [2*PDATA_SIZE-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [2*PDATA_SIZE-1:0] rsp_rdata,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  output logic [PADDR_SIZE-1:0]   wb_adr,
  output logic [PDATA_SIZE-1:0]   wb_dat_o,
  input  logic [PDATA_SIZE-1:0]   wb_dat_i,
  input  logic                    wb_ack
);

  localparam int DW = PDATA_SIZE;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_GAP, S_RESP} state_t;
  typedef enum logic [1:0] {K_SINGLE, K_DOUBLE, K_SNAP} kind_t;

  state_t state, state_nxt;

  kind_t               kind_q, kind_nxt;
  logic                we_q, we_nxt;
  logic [PADDR_SIZE-1:0] adr_q, adr_nxt;
  logic [2*DW-1:0]     wdata_q, wdata_nxt;
  logic [1:0]          phase_q, phase_nxt;
  logic [RW-1:0]       retry_q, retry_nxt;
  logic [TW-1:0]       tmo_q, tmo_nxt;
  logic [DW-1:0]       lo_q, lo_nxt, hi_q, hi_nxt;

  logic                cyc_q, cyc_nxt;
  logic                req_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic [2*DW-1:0]     rsp_rdata_nxt;
  logic                wb_we_nxt;
  logic [PADDR_SIZE-1:0] wb_adr_nxt;
  logic [DW-1:0]       wb_dat_nxt;

  logic start, finish, fail;

  // Snapshot reads fetch the high word first (phase 0) and again last (phase 2).
  function automatic logic [PADDR_SIZE-1:0] beat_adr(input kind_t k, input logic [1:0] ph,
                                                     input logic [PADDR_SIZE-1:0] a);
    logic [PADDR_SIZE-1:0] a1;
    a1 = a + PADDR_SIZE'(1);
    case (k)
      K_DOUBLE: beat_adr = (ph == 2'd1) ? a1 : a;
      K_SNAP:   beat_adr = (ph == 2'd1) ? a : a1;
      default:  beat_adr = a;
    endcase
  endfunction

  function automatic logic [DW-1:0] beat_dat(input logic [1:0] ph, input logic [2*DW-1:0] wd);
    beat_dat = (ph == 2'd1) ? wd[2*DW-1:DW] : wd[DW-1:0];
  endfunction

  assign wb_cyc = cyc_q;
  assign wb_stb = cyc_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state, beat sequencing and next values of all registered outputs.
  always_comb begin
    state_nxt     = state;
    kind_nxt      = kind_q;
    we_nxt        = we_q;
    adr_nxt       = adr_q;
    wdata_nxt     = wdata_q;
    phase_nxt     = phase_q;
    retry_nxt     = retry_q;
    tmo_nxt       = tmo_q;
    lo_nxt        = lo_q;
    hi_nxt        = hi_q;
    cyc_nxt       = 1'b0;
    wb_we_nxt     = wb_we;
    wb_adr_nxt    = wb_adr;
    wb_dat_nxt    = wb_dat_o;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    start         = 1'b0;
    finish        = 1'b0;
    fail          = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (!req_size64)                  kind_nxt = K_SINGLE;
          else if (req_consistent && !req_we) kind_nxt = K_SNAP;
          else                              kind_nxt = K_DOUBLE;
          we_nxt    = req_we;
          adr_nxt   = req_adr;
          wdata_nxt = req_wdata;
          phase_nxt = 2'd0;
          retry_nxt = '0;
          lo_nxt    = '0;
          hi_nxt    = '0;
          start     = 1'b1;
        end
      end
      S_BEAT: begin
        cyc_nxt = 1'b1;
        if (wb_ack) begin
          cyc_nxt   = 1'b0;
          state_nxt = S_GAP;
          case (kind_q)
            K_SINGLE: begin
              if (!we_q) lo_nxt = wb_dat_i;
              finish = 1'b1;
            end
            K_DOUBLE: begin
              if (phase_q == 2'd0) begin
                if (!we_q) lo_nxt = wb_dat_i;
                phase_nxt = 2'd1;
              end else begin
                if (!we_q) hi_nxt = wb_dat_i;
                finish = 1'b1;
              end
            end
            default: begin
              if (phase_q == 2'd0) begin
                hi_nxt    = wb_dat_i;
                phase_nxt = 2'd1;
              end else if (phase_q == 2'd1) begin
                lo_nxt    = wb_dat_i;
                phase_nxt = 2'd2;
              end else begin
                // hi1 always replaces hi0: on a match they are equal anyway,
                // on a mismatch it becomes the reference for the retry.
                hi_nxt = wb_dat_i;
                if (wb_dat_i == hi_q) begin
                  finish = 1'b1;
                end else begin
                  retry_nxt = retry_q + 1'b1;
                  if (retry_q == RETRY_LAST) begin
                    finish = 1'b1;
                    fail   = 1'b1;
                  end else begin
                    phase_nxt = 2'd1;
                  end
                end
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          cyc_nxt = 1'b0;
          finish  = 1'b1;
          fail    = 1'b1;
        end else begin
          tmo_nxt = tmo_q + 1'b1;
        end
      end
      S_GAP:   start     = 1'b1;
      default: state_nxt = S_IDLE;
    endcase

    if (start) begin
      state_nxt  = S_BEAT;
      cyc_nxt    = 1'b1;
      tmo_nxt    = '0;
      wb_we_nxt  = we_nxt;
      wb_adr_nxt = beat_adr(kind_nxt, phase_nxt, adr_nxt);
      wb_dat_nxt = we_nxt ? beat_dat(phase_nxt, wdata_nxt) : '0;
    end

    if (finish) begin
      state_nxt     = S_RESP;
      rsp_valid_nxt = 1'b1;
      rsp_err_nxt   = fail;
      rsp_rdata_nxt = we_q ? '0 : {hi_nxt, lo_nxt};
    end

    req_ready_nxt = (state_nxt == S_IDLE);
  end

  // Request latches, beat bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_q    <= K_SINGLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      phase_q   <= '0;
      retry_q   <= '0;
      tmo_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cyc_q     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wb_we     <= 1'b0;
      wb_adr    <= '0;
      wb_dat_o  <= '0;
    end else begin
      kind_q    <= kind_nxt;
      we_q      <= we_nxt;
      adr_q     <= adr_nxt;
      wdata_q   <= wdata_nxt;
      phase_q   <= phase_nxt;
      retry_q   <= retry_nxt;
      tmo_q     <= tmo_nxt;
      lo_q      <= lo_nxt;
      hi_q      <= hi_nxt;
      cyc_q     <= cyc_nxt;
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      wb_we     <= wb_we_nxt;
      wb_adr    <= wb_adr_nxt;
      wb_dat_o  <= wb_dat_nxt;
    end
  end

endmodule

// File: tb/tb_wb_word64_master.sv
// Bench for wb_word64_master: a scripted Wishbone slave with configurable
// ack delay, and a request-level reference model of beats and responses.
module tb_wb_word64_master;

  localparam int AW   = 30;
  localparam int TMO  = 8;
  localparam int RMAX = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we, req_size64, req_consistent;
  logic [AW-1:0] req_adr;
  logic [63:0]   req_wdata;
  logic          rsp_valid, rsp_err;
  logic [63:0]   rsp_rdata;
  logic          wb_cyc, wb_stb, wb_we, wb_ack;
  logic [AW-1:0] wb_adr;
  logic [31:0]   wb_dat_o, wb_dat_i;

  wb_word64_master #(
    .PADDR_SIZE(AW),
    .PDATA_SIZE(32),
    .TIMEOUT_CYCLES(TMO),
    .RETRY_MAX(RMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size64(req_size64), .req_consistent(req_consistent),
    .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [31:0]   dat;
  } beat_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  beat_t       obs_q[$];
  beat_t       exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] script[$];

  int unsigned d_cfg       = 1;
  int          noack_from  = -1;
  int          beat_starts = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: acks d_cfg cycles after the strobe rises, returns scripted read data.
  initial begin : slave
    int unsigned   cnt;
    bit            in_beat;
    logic [AW-1:0] adr0;
    beat_t         b;
    cnt = 0; in_beat = 0; adr0 = '0;
    wb_ack = 1'b0; wb_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      check("stb_eq_cyc", 64'(wb_stb), 64'(wb_cyc));
      if (wb_ack) begin
        wb_ack = 1'b0; wb_dat_i = '0;
        check("cyc_low_after_ack", 64'(wb_cyc), 64'd0);
        check("beat_len", 64'(cnt), 64'(d_cfg + 1));
        cnt = 0; in_beat = 0;
      end else if (wb_cyc) begin
        if (!in_beat) begin
          in_beat = 1; beat_starts++; adr0 = wb_adr; cnt = 0;
        end
        cnt++;
        if (noack_from != beat_starts - 1 && cnt == d_cfg + 1) begin
          check("adr_stable", 64'(wb_adr), 64'(adr0));
          b.adr = wb_adr; b.we = wb_we; b.dat = wb_dat_o;
          obs_q.push_back(b);
          wb_ack = 1'b1;
          if (!wb_we) wb_dat_i = (rd_q.size() > 0) ? rd_q.pop_front() : $urandom;
        end
      end else if (in_beat) begin
        if (noack_from == beat_starts - 1) check("timeout_len", 64'(cnt), 64'(TMO));
        in_beat = 0; cnt = 0;
      end
    end
  end

  task automatic push_exp(input logic [AW-1:0] a, input logic we, input logic [31:0] dat);
    beat_t b;
    b.adr = a; b.we = we; b.dat = dat;
    exp_q.push_back(b);
  endtask

  // One request: model the expected beats/response from `script`, then run it.
  task automatic do_req(input string tag, input bit we, input bit s64, input bit cons,
                        input logic [AW-1:0] a, input logic [63:0] wd,
                        input int unsigned d, input int nack);
    logic [AW-1:0] a1;
    logic [63:0]   exp_rd;
    bit            exp_err;
    logic [31:0]   hi0, hi1, lo;
    int unsigned   k, retry, lat, n, nb, starts;
    a1 = a + 1'b1;
    exp_q.delete(); obs_q.delete();
    exp_err = 0; exp_rd = '0;
    if (!s64) begin
      push_exp(a, we, wd[31:0]);
      if (!we) exp_rd = {32'h0, script[0]};
    end else if (we || !cons) begin
      push_exp(a, we, wd[31:0]);
      push_exp(a1, we, wd[63:32]);
      if (!we) exp_rd = {script[1], script[0]};
    end else begin
      k = 0; retry = 0;
      push_exp(a1, 1'b0, '0); hi0 = script[k]; k++;
      forever begin
        push_exp(a, 1'b0, '0);  lo  = script[k]; k++;
        push_exp(a1, 1'b0, '0); hi1 = script[k]; k++;
        if (hi1 == hi0) break;
        retry++;
        if (retry > RMAX) begin exp_err = 1; break; end
        hi0 = hi1;
      end
      exp_rd = {hi1, lo};
    end
    if (nack >= 0) begin
      exp_err = 1;
      while (exp_q.size() > nack) void'(exp_q.pop_back());
      exp_rd = (!we && s64 && nack == 1) ? {32'h0, script[0]} : 64'h0;
      starts = nack + 1;
    end else begin
      starts = exp_q.size();
    end
    nb = exp_q.size();

    rd_q = script; d_cfg = d; noack_from = nack; beat_starts = 0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_size64 = s64; req_consistent = cons;
    req_adr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; req_adr = AW'($urandom); req_wdata = {$urandom, $urandom};
    lat = 1;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'(exp_err));
    check({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
    if (nack < 0) check({tag, "_latency"}, 64'(lat), 64'(nb * (d + 1) + (nb - 1) + 1));
    @(negedge clk);
    check({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
    check({tag, "_beat_starts"}, 64'(beat_starts), 64'(starts));
    check({tag, "_beat_count"}, 64'(obs_q.size()), 64'(nb));
    for (int i = 0; i < nb && i < obs_q.size(); i++) begin
      check({tag, "_beat_adr"}, 64'(obs_q[i].adr), 64'(exp_q[i].adr));
      check({tag, "_beat_we"}, 64'(obs_q[i].we), 64'(exp_q[i].we));
      if (exp_q[i].we) check({tag, "_beat_dat"}, 64'(obs_q[i].dat), 64'(exp_q[i].dat));
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit            we, s64, cons, saw;
    logic [AW-1:0] a;
    logic [31:0]   h;
    int            nack, n;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size64 = 1'b0;
    req_consistent = 1'b0; req_adr = '0; req_wdata = '0;

    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_cyc", 64'(wb_cyc), 64'd0);
    check("rst_stb", 64'(wb_stb), 64'd0);
    check("rst_we", 64'(wb_we), 64'd0);
    check("rst_adr", 64'(wb_adr), 64'd0);
    check("rst_dat", 64'(wb_dat_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    script.delete();
    do_req("wr64", 1, 1, 0, AW'(32'h1000), 64'h0000_0001_8000_0000, 1, -1);

    script = '{32'hDEAD_BEEF, 32'h1234_5678};
    do_req("rd64", 0, 1, 0, AW'(32'h2468), '0, 2, -1);

    script = '{32'h5, 32'hFFFF_FFFF, 32'h6, 32'h2, 32'h6};
    do_req("snap_retry1", 0, 1, 1, AW'(32'h4000), '0, 1, -1);

    script = '{32'h0, $urandom, 32'h1, $urandom, 32'h2, $urandom, 32'h3, $urandom, 32'h4};
    do_req("snap_exhaust", 0, 1, 1, AW'(32'h4000), '0, 1, -1);

    script.delete();
    do_req("noack", 0, 1, 0, AW'(32'h3000), '0, 1, 0);

    script = '{$urandom, $urandom};
    do_req("noack_hi", 0, 1, 0, AW'(32'h3000), '0, 2, 1);

    script = '{$urandom, $urandom};
    do_req("wrap", 0, 1, 0, '1, '0, 1, -1);

    script = '{$urandom};
    do_req("rd32", 0, 0, 1, AW'($urandom), '0, 3, -1);

    for (int it = 0; it < 40; it++) begin
      we   = $urandom_range(0, 1);
      s64  = $urandom_range(0, 3) != 0;
      cons = $urandom_range(0, 1);
      a    = ($urandom_range(0, 5) == 0) ? '1 : AW'($urandom);
      script.delete();
      if (s64 && cons && !we) begin
        h = $urandom;
        for (int i = 0; i < 9; i++) begin
          if (i % 2 == 0) begin
            if ($urandom_range(0, 2) == 0) h = h + 1;
            script.push_back(h);
          end else begin
            script.push_back($urandom);
          end
        end
        nack = -1;
      end else begin
        script.push_back($urandom); script.push_back($urandom);
        nack = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, s64 ? 1 : 0)) : -1;
      end
      do_req("rand", we, s64, cons, a, {$urandom, $urandom}, $urandom_range(1, 4), nack);
    end

    // Reset asserted in the middle of the second beat of a 64-bit write.
    rd_q.delete(); d_cfg = 3; noack_from = -1; beat_starts = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size64 = 1'b1; req_consistent = 1'b0;
    req_adr = AW'(32'h5000); req_wdata = {$urandom, $urandom};
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (beat_starts < 2 && n < 100) begin @(negedge clk); n++; end
    check("rst_mid_reached_beat2", 64'(beat_starts >= 2), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_cyc", 64'(wb_cyc), 64'd0);
    check("rst_mid_stb", 64'(wb_stb), 64'd0);
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) saw = 1;
    end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || wb_cyc) saw = 1;
    end
    check("rst_mid_no_rsp", 64'(saw), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
